// File: rtl/sky130_fd_io__pwrseq_pkg.sv
// Shared types for the HVC power-ring sequencer: FSM state encoding and fault counter width.
package sky130_fd_io__pwrseq_pkg;

  localparam int FAULT_CNT_W = 8;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    EN_IO    = 3'd1,
    REL_HOLD = 3'd2,
    EN_ANA   = 3'd3,
    ON       = 3'd4,
    PD_ANA   = 3'd5,
    PD_HOLD  = 3'd6,
    PD_IO    = 3'd7
  } pwrseq_state_t;

  // States from which an orderly shutdown request is honoured.
  function automatic logic is_up(input pwrseq_state_t s);
    return (s == EN_IO) || (s == REL_HOLD) || (s == EN_ANA) || (s == ON);
  endfunction

endpackage

// File: rtl/sky130_fd_io__pwrseq_debounce.sv
// Two-flop synchronisers for VDDIO/VCCD presence plus a saturating stable-high counter.
module sky130_fd_io__pwrseq_debounce
  import sky130_fd_io__pwrseq_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vddio,
  input  logic i_vccd,
  output logic o_io_s,
  output logic o_cd_s,
  output logic o_deb_ok
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

  logic [1:0]       r_io_sync;
  logic [1:0]       r_cd_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_both;

  assign w_both = r_io_sync[1] & r_cd_sync[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_io_sync <= '0;
      r_cd_sync <= '0;
      r_cnt     <= '0;
    end else begin
      r_io_sync <= {r_io_sync[0], i_vddio};
      r_cd_sync <= {r_cd_sync[0], i_vccd};
      if (!w_both)
        r_cnt <= '0;
      else if (r_cnt != DEB_MAX)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_io_s   = r_io_sync[1];
  assign o_cd_s   = r_cd_sync[1];
  // Qualified by the live level so a rail drop never starts a sequence.
  assign o_deb_ok = w_both & (r_cnt == DEB_MAX);

endmodule

// File: rtl/sky130_fd_io__hvc_pwrseq_ctrl.sv
// HVC power-ring sequencer: timed IO enable -> hold release -> analog enable -> power-good.
// Optional fault counter port/logic enabled by SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN.
module sky130_fd_io__hvc_pwrseq_ctrl
  import sky130_fd_io__pwrseq_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int STEP_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VDDIO_PRESENT,
  input  logic       VCCD_PRESENT,
  input  logic       VDDA_PRESENT,
  input  logic       SHUTDOWN_REQ,
  output logic       ENABLE_H,
  output logic       HLD_H_N,
  output logic       ENABLE_VDDA_H,
  output logic       ENABLE_VSWITCH_H,
  output logic       PWR_GOOD,
`ifdef SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN
  output logic [FAULT_CNT_W-1:0] FAULT_CNT,
`endif
  output logic [2:0] STATE
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic          w_io_s;
  logic          w_cd_s;
  logic          w_deb_ok;
  logic          w_va_s;
  logic [1:0]    r_va_sync;

  pwrseq_state_t r_state;
  pwrseq_state_t w_state_nxt;
  logic [CNT_W-1:0] r_step_cnt;
  logic          w_step_done;
  logic          w_dwell;
  logic          w_emerg;

  logic          r_en;
  logic          r_hld;
  logic          r_ana;
  logic          r_pg;
  logic          w_en_nxt;
  logic          w_hld_nxt;
  logic          w_ana_nxt;
  logic          w_pg_nxt;

  sky130_fd_io__pwrseq_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_vddio  (VDDIO_PRESENT),
    .i_vccd   (VCCD_PRESENT),
    .o_io_s   (w_io_s),
    .o_cd_s   (w_cd_s),
    .o_deb_ok (w_deb_ok)
  );

  assign w_va_s      = r_va_sync[1];
  assign w_step_done = (r_step_cnt == STEP_LAST);
  assign w_dwell     = (r_state == EN_IO) || (r_state == REL_HOLD) || (r_state == EN_ANA) ||
                       (r_state == PD_ANA) || (r_state == PD_HOLD);

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_hld_nxt   = r_hld;
    w_ana_nxt   = r_ana;
    w_pg_nxt    = r_pg;
    w_emerg     = 1'b0;
    // Rail loss beats shutdown, which beats any timed step.
    if ((r_state != OFF) && !(w_io_s && w_cd_s)) begin
      w_emerg     = 1'b1;
      w_state_nxt = OFF;
      w_en_nxt    = 1'b0;
      w_hld_nxt   = 1'b0;
      w_ana_nxt   = 1'b0;
      w_pg_nxt    = 1'b0;
    end else if (is_up(r_state) && SHUTDOWN_REQ) begin
      w_state_nxt = PD_ANA;
      w_ana_nxt   = 1'b0;
      w_pg_nxt    = 1'b0;
    end else begin
      case (r_state)
        OFF: if (w_deb_ok && !SHUTDOWN_REQ) begin
          w_state_nxt = EN_IO;
          w_en_nxt    = 1'b1;
        end
        EN_IO: if (w_step_done) begin
          w_state_nxt = REL_HOLD;
          w_hld_nxt   = 1'b1;
        end
        REL_HOLD: if (w_step_done) begin
          if (w_va_s) begin
            w_state_nxt = EN_ANA;
            w_ana_nxt   = 1'b1;
          end else begin
            w_state_nxt = ON;
            w_pg_nxt    = 1'b1;
          end
        end
        EN_ANA: if (w_step_done) begin
          w_state_nxt = ON;
          w_pg_nxt    = 1'b1;
        end
        ON: begin
          if (r_ana && !w_va_s) begin
            w_ana_nxt = 1'b0;
          end else if (!r_ana && w_va_s) begin
            w_state_nxt = EN_ANA;
            w_ana_nxt   = 1'b1;
          end
        end
        PD_ANA: if (w_step_done) begin
          w_state_nxt = PD_HOLD;
          w_hld_nxt   = 1'b0;
        end
        PD_HOLD: if (w_step_done) begin
          w_state_nxt = PD_IO;
          w_en_nxt    = 1'b0;
        end
        PD_IO:   w_state_nxt = OFF;
        default: w_state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_va_sync  <= '0;
      r_state    <= OFF;
      r_step_cnt <= '0;
      r_en       <= 1'b0;
      r_hld      <= 1'b0;
      r_ana      <= 1'b0;
      r_pg       <= 1'b0;
    end else begin
      r_va_sync  <= {r_va_sync[0], VDDA_PRESENT};
      r_state    <= w_state_nxt;
      r_step_cnt <= ((w_state_nxt != r_state) || !w_dwell) ? '0 : r_step_cnt + CNT_W'(1);
      r_en       <= w_en_nxt;
      r_hld      <= w_hld_nxt;
      r_ana      <= w_ana_nxt;
      r_pg       <= w_pg_nxt;
    end
  end

`ifdef SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN
  logic [FAULT_CNT_W-1:0] r_fault_cnt;

  always_ff @(posedge CLK) begin
    if (RESET)
      r_fault_cnt <= '0;
    else if (w_emerg && (r_fault_cnt != {FAULT_CNT_W{1'b1}}))
      r_fault_cnt <= r_fault_cnt + FAULT_CNT_W'(1);
  end

  assign FAULT_CNT = r_fault_cnt;
`endif

  assign ENABLE_H         = r_en;
  assign HLD_H_N          = r_hld;
  assign ENABLE_VDDA_H    = r_ana;
  assign ENABLE_VSWITCH_H = r_ana;
  assign PWR_GOOD         = r_pg;
  assign STATE            = r_state;

endmodule

// File: tb/tb_sky130_fd_io__hvc_pwrseq_ctrl.sv
// Bench for the HVC power-ring sequencer: directed timing points plus random rail/shutdown/reset traffic
// against a time-based reference model. Checks FAULT_CNT when SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN is defined.
module tb_sky130_fd_io__hvc_pwrseq_ctrl;

  localparam int DEB  = 16;
  localparam int STEP = 8;

  // State codes as published for the STATE port.
  localparam int S_OFF = 0, S_EN_IO = 1, S_REL_HOLD = 2, S_EN_ANA = 3,
                 S_ON = 4, S_PD_ANA = 5, S_PD_HOLD = 6, S_PD_IO = 7;

  logic       CLK = 1'b0;
  logic       RESET, VDDIO_PRESENT, VCCD_PRESENT, VDDA_PRESENT, SHUTDOWN_REQ;
  logic       ENABLE_H, HLD_H_N, ENABLE_VDDA_H, ENABLE_VSWITCH_H, PWR_GOOD;
  logic [2:0] STATE;
`ifdef SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN
  logic [7:0] FAULT_CNT;
`endif

  always #5 CLK = ~CLK;

  sky130_fd_io__hvc_pwrseq_ctrl #(
    .DEB_CYCLES  (DEB),
    .STEP_CYCLES (STEP),
    .CNT_W       (8)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .VDDIO_PRESENT    (VDDIO_PRESENT),
    .VCCD_PRESENT     (VCCD_PRESENT),
    .VDDA_PRESENT     (VDDA_PRESENT),
    .SHUTDOWN_REQ     (SHUTDOWN_REQ),
    .ENABLE_H         (ENABLE_H),
    .HLD_H_N          (HLD_H_N),
    .ENABLE_VDDA_H    (ENABLE_VDDA_H),
    .ENABLE_VSWITCH_H (ENABLE_VSWITCH_H),
    .PWR_GOOD         (PWR_GOOD),
`ifdef SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN
    .FAULT_CNT        (FAULT_CNT),
`endif
    .STATE            (STATE)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int t0       = 0;

  // Reference model: inputs reach the logic two edges late; the debounce is a run length
  // of good samples; each phase remembers the edge it was entered on.
  bit q_io[$], q_cd[$], q_va[$];
  int run_good;
  int ph;
  int entered;
  bit m_en, m_hld, m_ana, m_pg;
  int m_faults;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    q_io.delete(); q_io.push_back(1'b0); q_io.push_back(1'b0);
    q_cd.delete(); q_cd.push_back(1'b0); q_cd.push_back(1'b0);
    q_va.delete(); q_va.push_back(1'b0); q_va.push_back(1'b0);
    run_good = 0;
    ph       = S_OFF;
    entered  = edge_n;
    m_en = 0; m_hld = 0; m_ana = 0; m_pg = 0;
    m_faults = 0;
  endtask

  task automatic enter(input int p);
    ph      = p;
    entered = edge_n;
  endtask

  task automatic model_step();
    bit s_io, s_cd, s_va, good;
    int elapsed;
    s_io = q_io.pop_front(); q_io.push_back(VDDIO_PRESENT);
    s_cd = q_cd.pop_front(); q_cd.push_back(VCCD_PRESENT);
    s_va = q_va.pop_front(); q_va.push_back(VDDA_PRESENT);
    if (RESET) begin
      model_reset();
      return;
    end
    good     = s_io && s_cd;
    run_good = good ? run_good + 1 : 0;
    elapsed  = edge_n - entered;
    if (ph != S_OFF && !good) begin
      enter(S_OFF);
      m_en = 0; m_hld = 0; m_ana = 0; m_pg = 0;
      if (m_faults < 255) m_faults++;
    end else if ((ph == S_EN_IO || ph == S_REL_HOLD || ph == S_EN_ANA || ph == S_ON) && SHUTDOWN_REQ) begin
      enter(S_PD_ANA);
      m_pg = 0; m_ana = 0;
    end else begin
      case (ph)
        S_OFF:      if (run_good > DEB && !SHUTDOWN_REQ) begin enter(S_EN_IO); m_en = 1; end
        S_EN_IO:    if (elapsed == STEP) begin enter(S_REL_HOLD); m_hld = 1; end
        S_REL_HOLD: if (elapsed == STEP) begin
                      if (s_va) begin enter(S_EN_ANA); m_ana = 1; end
                      else begin enter(S_ON); m_pg = 1; end
                    end
        S_EN_ANA:   if (elapsed == STEP) begin enter(S_ON); m_pg = 1; end
        S_ON:       if (m_ana && !s_va) m_ana = 0;
                    else if (!m_ana && s_va) begin enter(S_EN_ANA); m_ana = 1; end
        S_PD_ANA:   if (elapsed == STEP) begin enter(S_PD_HOLD); m_hld = 0; end
        S_PD_HOLD:  if (elapsed == STEP) begin enter(S_PD_IO); m_en = 0; end
        default:    enter(S_OFF);
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("ENABLE_H", ENABLE_H, m_en);
    chk("HLD_H_N", HLD_H_N, m_hld);
    chk("ENABLE_VDDA_H", ENABLE_VDDA_H, m_ana);
    chk("ENABLE_VSWITCH_H", ENABLE_VSWITCH_H, m_ana);
    chk("PWR_GOOD", PWR_GOOD, m_pg);
    chk("STATE", STATE, 8'(ph));
`ifdef SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN
    chk("FAULT_CNT", FAULT_CNT, 8'(m_faults));
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_n++;
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run_to(input int e);
    while (edge_n - t0 < e) tick();
  endtask

  initial begin
    RESET = 1; VDDIO_PRESENT = 0; VCCD_PRESENT = 0; VDDA_PRESENT = 0; SHUTDOWN_REQ = 0;
    model_reset();
    repeat (3) tick();
    chk("reset_state", STATE, 8'd0);
    chk("reset_en", ENABLE_H, 8'd0);
    chk("reset_pg", PWR_GOOD, 8'd0);

    // Power-up with all three rails.
    RESET = 0; VDDIO_PRESENT = 1; VCCD_PRESENT = 1; VDDA_PRESENT = 1;
    t0 = edge_n;
    run_to(18); chk("pu_en_18", ENABLE_H, 8'd0);
    run_to(19); chk("pu_en_19", ENABLE_H, 8'd1);
    run_to(26); chk("pu_hld_26", HLD_H_N, 8'd0);
    run_to(27); chk("pu_hld_27", HLD_H_N, 8'd1);
    run_to(34); chk("pu_ana_34", ENABLE_VDDA_H, 8'd0);
    run_to(35); chk("pu_ana_35", ENABLE_VDDA_H, 8'd1); chk("pu_vsw_35", ENABLE_VSWITCH_H, 8'd1);
    run_to(42); chk("pu_pg_42", PWR_GOOD, 8'd0);
    run_to(43); chk("pu_pg_43", PWR_GOOD, 8'd1); chk("pu_state_on", STATE, 8'd4);

    // Orderly shutdown from ON, request held afterwards.
    run_to(48);
    SHUTDOWN_REQ = 1; t0 = edge_n;
    run_to(1);  chk("sd_pg_1", PWR_GOOD, 8'd0); chk("sd_ana_1", ENABLE_VDDA_H, 8'd0);
    run_to(8);  chk("sd_hld_8", HLD_H_N, 8'd1);
    run_to(9);  chk("sd_hld_9", HLD_H_N, 8'd0);
    run_to(16); chk("sd_en_16", ENABLE_H, 8'd1);
    run_to(17); chk("sd_en_17", ENABLE_H, 8'd0); chk("sd_state_17", STATE, 8'd7);
    run_to(18); chk("sd_state_18", STATE, 8'd0);
    run_to(30); chk("sd_hold_off", STATE, 8'd0);

    // Release: rails are still debounced, so the sequence restarts on the next edge.
    SHUTDOWN_REQ = 0; t0 = edge_n;
    run_to(1);  chk("rel_en_1", ENABLE_H, 8'd1);
    run_to(25); chk("rel_pg_25", PWR_GOOD, 8'd1);

    // Emergency during PD_ANA.
    SHUTDOWN_REQ = 1; t0 = edge_n;
    run_to(3);
    VDDIO_PRESENT = 0; t0 = edge_n;
    run_to(2); chk("em_en_2", ENABLE_H, 8'd1);
    run_to(3); chk("em_en_3", ENABLE_H, 8'd0); chk("em_hld_3", HLD_H_N, 8'd0);
    chk("em_state_3", STATE, 8'd0);
`ifdef SKY130_FD_IO_PWRSEQ_FAULT_CNT_EN
    chk("em_fault", FAULT_CNT, 8'd1);
`endif
    SHUTDOWN_REQ = 0;

    // Glitch on VCCD and power-up without VDDA.
    RESET = 1; repeat (2) tick();
    RESET = 0; VDDIO_PRESENT = 1; VCCD_PRESENT = 1; VDDA_PRESENT = 0;
    t0 = edge_n;
    run_to(10); VCCD_PRESENT = 0;
    run_to(11); VCCD_PRESENT = 1;
    run_to(29); chk("gl_en_29", ENABLE_H, 8'd0);
    run_to(30); chk("gl_en_30", ENABLE_H, 8'd1);
    run_to(45); chk("nv_pg_45", PWR_GOOD, 8'd0);
    run_to(46); chk("nv_pg_46", PWR_GOOD, 8'd1); chk("nv_ana_46", ENABLE_VDDA_H, 8'd0);
    run_to(50);
    VDDA_PRESENT = 1; t0 = edge_n;
    run_to(2); chk("va_ana_2", ENABLE_VDDA_H, 8'd0);
    run_to(3); chk("va_ana_3", ENABLE_VDDA_H, 8'd1); chk("va_pg_3", PWR_GOOD, 8'd1);
    run_to(15);

    // Reset pulse in ON, then re-sequence.
    RESET = 1; tick();
    chk("rst_en", ENABLE_H, 8'd0); chk("rst_state", STATE, 8'd0); chk("rst_pg", PWR_GOOD, 8'd0);
    RESET = 0; t0 = edge_n;
    run_to(18); chk("rs_en_18", ENABLE_H, 8'd0);
    run_to(19); chk("rs_en_19", ENABLE_H, 8'd1);
    run_to(43); chk("rs_pg_43", PWR_GOOD, 8'd1);

    // Random traffic against the model.
    for (int k = 0; k < 90; k++) begin
      int act, len;
      act = $urandom_range(0, 9);
      case (act)
        0, 1, 2, 3: begin
          VDDIO_PRESENT = 1; VCCD_PRESENT = 1; SHUTDOWN_REQ = 0;
          len = $urandom_range(20, 70);
        end
        4, 5: begin SHUTDOWN_REQ = 1; len = $urandom_range(5, 40); end
        6: begin
          if ($urandom_range(0, 1) == 0) VDDIO_PRESENT = 0; else VCCD_PRESENT = 0;
          repeat ($urandom_range(1, 4)) tick();
          VDDIO_PRESENT = 1; VCCD_PRESENT = 1;
          len = $urandom_range(1, 10);
        end
        7: begin VDDA_PRESENT = ~VDDA_PRESENT; len = $urandom_range(2, 30); end
        8: begin SHUTDOWN_REQ = ~SHUTDOWN_REQ; len = $urandom_range(1, 3); end
        default: begin
          if ($urandom_range(0, 2) == 0) begin
            RESET = 1;
            repeat ($urandom_range(1, 2)) tick();
            RESET = 0;
          end
          len = $urandom_range(1, 5);
        end
      endcase
      repeat (len) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
